// File: rtl/hsem_sem_bank.sv
// +----------------------------------------------------------------------------
// | hsem_sem_bank: SEM_NUM hardware semaphores shared by CORE_NUM cores, with
// | owner-checked release, read-lock, keyed clear-all, release irqs, errors.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module hsem_sem_bank #(
  parameter int          SEM_NUM  = 16,
  parameter int          CORE_NUM = 2,
  parameter int          ADDR_W   = 9,
  parameter logic [15:0] CLR_KEY  = 16'hA5A5
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   reg_addr,
  input  logic [31:0]         ihwdata,
  input  logic [1:0]          hmaster,
  output logic [31:0]         ihrdata,
  output logic [CORE_NUM-1:0] irq,
  output logic                err_irq
);

  logic [SEM_NUM-1:0]                lock_q, lock_d;
  logic [SEM_NUM-1:0][7:0]           pid_q, pid_d;
  logic [SEM_NUM-1:0][1:0]           cid_q, cid_d;
  logic [CORE_NUM-1:0][SEM_NUM-1:0]  ier_q, ier_d;
  logic [CORE_NUM-1:0][SEM_NUM-1:0]  isr_q, isr_d;
  logic [CORE_NUM-1:0][SEM_NUM-1:0]  own;
  logic [3:0]                        err_q, err_d;
  logic [4:0]                        eidx_q, eidx_d;
  logic [SEM_NUM-1:0]                rel;

  logic [31:0] addr;
  logic [4:0]  sidx;
  logic [1:0]  cidx;
  logic [1:0]  ridx;
  logic [3:0]  midx;
  logic        aligned, sem_hit, rlr_hit, core_hit, misc_hit, hm_ok, key_ok;
  logic [7:0]  wpid;

  assign addr     = 32'(reg_addr);
  assign sidx     = addr[6:2];
  assign cidx     = addr[5:4];
  assign ridx     = addr[3:2];
  assign midx     = addr[5:2];
  assign aligned  = (addr[1:0] == 2'd0);
  assign sem_hit  = aligned && (addr[31:7] == 25'd0);
  assign rlr_hit  = aligned && (addr[31:7] == 25'd2);
  assign core_hit = aligned && (addr[31:6] == 26'd2);
  assign misc_hit = aligned && (addr[31:6] == 26'd3);
  assign hm_ok    = ({30'd0, hmaster} < 32'(CORE_NUM));
  assign key_ok   = (ihwdata[31:16] == CLR_KEY);
  assign wpid     = ihwdata[15:8];

  for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
    for (genvar i = 0; i < SEM_NUM; i++) begin : g_own
      assign own[c][i] = lock_q[i] && (cid_q[i] == 2'(c));
    end
    assign irq[c] = |(isr_q[c] & ier_q[c]);
  end

  assign err_irq = |err_q;

  always_comb begin
    lock_d  = lock_q;
    pid_d   = pid_q;
    cid_d   = cid_q;
    ier_d   = ier_q;
    isr_d   = isr_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    rel     = '0;
    ihrdata = '0;

    // Read mux; an RLR read of a free semaphore claims it for the reader.
    for (int i = 0; i < SEM_NUM; i++) begin
      if ((sem_hit || rlr_hit) && (sidx == 5'(i))) begin
        ihrdata = {14'd0, cid_q[i], pid_q[i], 7'd0, lock_q[i]};
        if (rlr_hit && rd_en && hm_ok && !lock_q[i]) begin
          ihrdata  = {14'd0, hmaster, 15'd0, 1'b1};
          lock_d[i] = 1'b1;
          pid_d[i]  = 8'd0;
          cid_d[i]  = hmaster;
        end
      end
    end

    for (int c = 0; c < CORE_NUM; c++) begin
      if (core_hit && (cidx == 2'(c))) begin
        case (ridx)
          2'd0:    ihrdata = 32'(ier_q[c]);
          2'd1:    ihrdata = 32'(isr_q[c]);
          2'd3:    ihrdata = 32'(own[c]);
          default: ihrdata = '0;
        endcase
      end
    end

    if (misc_hit && (midx == 4'd0)) begin
      ihrdata = {19'd0, eidx_q, 4'd0, err_q};
    end

    if (wr_en) begin
      if (sem_hit && hm_ok) begin
        for (int i = 0; i < SEM_NUM; i++) begin
          if (sidx == 5'(i)) begin
            if (ihwdata[0]) begin
              if (!lock_q[i]) begin
                lock_d[i] = 1'b1;
                pid_d[i]  = wpid;
                cid_d[i]  = hmaster;
              end
            end else if (lock_q[i]) begin
              if ((cid_q[i] == hmaster) && (pid_q[i] == wpid)) begin
                lock_d[i] = 1'b0;
                pid_d[i]  = 8'd0;
                cid_d[i]  = 2'd0;
                rel[i]    = 1'b1;
              end else begin
                err_d[hmaster] = 1'b1;
                // Only the first error since ERR was last empty records its index.
                if ((err_q == 4'd0) && (eidx_q == 5'd0)) begin
                  eidx_d = 5'(i);
                end
              end
            end
          end
        end
      end

      for (int c = 0; c < CORE_NUM; c++) begin
        if (core_hit && (cidx == 2'(c))) begin
          if (ridx == 2'd0) begin
            ier_d[c] = ihwdata[SEM_NUM-1:0];
          end else if (ridx == 2'd2) begin
            isr_d[c] = isr_q[c] & ~ihwdata[SEM_NUM-1:0];
          end
        end
      end

      if (misc_hit && (midx == 4'd1)) begin
        err_d = err_q & ~ihwdata[3:0];
        if (err_d == 4'd0) begin
          eidx_d = 5'd0;
        end
      end

      if (misc_hit && (midx == 4'd2) && hm_ok && key_ok) begin
        for (int i = 0; i < SEM_NUM; i++) begin
          if (lock_q[i] && (cid_q[i] == hmaster) && (pid_q[i] == wpid)) begin
            lock_d[i] = 1'b0;
            pid_d[i]  = 8'd0;
            cid_d[i]  = 2'd0;
            rel[i]    = 1'b1;
          end
        end
      end
    end

    for (int c = 0; c < CORE_NUM; c++) begin
      if (hmaster != 2'(c)) begin
        isr_d[c] = isr_d[c] | rel;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      lock_q <= '0;
      pid_q  <= '0;
      cid_q  <= '0;
      ier_q  <= '0;
      isr_q  <= '0;
      err_q  <= '0;
      eidx_q <= '0;
    end else begin
      lock_q <= lock_d;
      pid_q  <= pid_d;
      cid_q  <= cid_d;
      ier_q  <= ier_d;
      isr_q  <= isr_d;
      err_q  <= err_d;
      eidx_q <= eidx_d;
    end
  end

endmodule

`default_nettype wire
